// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and op-class helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MF    = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for a multi-cycle countdown.
  function automatic logic is_busy_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Operation bus between the E stage (master) and the MDU sequencer (slave).
// start is a one-cycle strobe, only legal while busy is low; busy high means
// the unit accepts no new mult/div and mfhi/mflo must wait.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_val, rt_val, input busy, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational product/quotient/remainder. res_wr is low when the result
// must not reach HI/LO (divide by zero).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_wr
);

  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, div_a, div_b, q_raw, r_raw;
  logic        b_nz;

  // Signed divide works on magnitudes; 0x8000_0000 / -1 falls out as
  // quotient 0x8000_0000, remainder 0 without a special case.
  always_comb begin
    b_nz  = (b != 32'd0);
    abs_a = a[31] ? -a : a;
    abs_b = b[31] ? -b : b;
    div_a = (op == MD_DIV) ? abs_a : a;
    div_b = !b_nz ? 32'd1 : ((op == MD_DIV) ? abs_b : b);
    q_raw = div_a / div_b;
    r_raw = div_a % div_b;
    prod   = '0;
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;
    case (op)
      MD_MULT: begin
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        {res_hi, res_lo} = prod;
        res_wr = 1'b1;
      end
      MD_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        {res_hi, res_lo} = prod;
        res_wr = 1'b1;
      end
      MD_DIV: begin
        res_lo = (a[31] ^ b[31]) ? -q_raw : q_raw;
        res_hi = a[31] ? -r_raw : r_raw;
        res_wr = b_nz;
      end
      MD_DIVU: begin
        res_lo = q_raw;
        res_hi = r_raw;
        res_wr = b_nz;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// MDU sequencer beside E: fixed-latency busy countdown, HI/LO ownership and
// the front-end hold/bubble controls for PC, F/D and D/E.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_if.slave       bus,
  input  logic       d_is_md,
  input  logic       hazard_stall,
  output logic       en_pc,
  output logic       en_fd,
  output logic       clr_de,
  output mdu_state_e state_dbg
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e  state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0] hi_q, lo_q, pend_hi, pend_lo;
  logic        pend_wr;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;
  logic        take, commit, wr_hi, wr_lo, md_stall, stall;

  mdu_arith u_arith (
    .op     (bus.op),
    .a      (bus.rs_val),
    .b      (bus.rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .res_wr (res_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
      end
      if (commit && pend_wr) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
      if (wr_hi) hi_q <= bus.rs_val;
      if (wr_lo) lo_q <= bus.rs_val;
    end
  end

  // The counter holds the number of busy cycles left including the current one.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_busy_op(bus.op)) begin
            take    = 1'b1;
            state_n = RUN;
            cnt_n   = is_div_op(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (bus.op == MD_MTHI) begin
            wr_hi = 1'b1;
          end else if (bus.op == MD_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt <= CNT_W'(1)) begin
          commit  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy  = (state == RUN);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign state_dbg = state;

  assign md_stall = d_is_md & (bus.busy | (bus.start & is_busy_op(bus.op)));
  assign stall    = md_stall | hazard_stall;
  assign en_pc    = ~stall;
  assign en_fd    = ~stall;
  assign clr_de   = stall;

  start_in_run_a: assert property (@(posedge clk) disable iff (reset)
    !(bus.start && state == RUN));

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed table, hand-written corner sequences and
// randomized ops checked against a plain-arithmetic model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_is_md, hazard_stall;
  logic       en_pc, en_fd, clr_de;
  mdu_state_e state_dbg;

  mdu_if bus();

  mdu_sequencer #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .d_is_md      (d_is_md),
    .hazard_stall (hazard_stall),
    .en_pc        (en_pc),
    .en_fd        (en_fd),
    .clr_de       (clr_de),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    logic        dmd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    h = m_hi;
    l = m_lo;
    sa = a;
    sb = b;
    case (o)
      MD_MULT: begin
        p = longint'(sa) * longint'(sb);
        h = p[63:32];
        l = p[31:0];
      end
      MD_MULTU: begin
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        h = pu[63:32];
        l = pu[31:0];
      end
      MD_DIV: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
      MD_DIVU: if (b != 0) begin
        l = a / b;
        h = a % b;
      end
      default: ;
    endcase
  endfunction

  // Called just after a rising edge; returns just after a rising edge.
  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    bus.start = 1'b1; bus.op = o; bus.rs_val = v;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE;
    if (o == MD_MTHI) m_hi = v; else m_lo = v;
  endtask

  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input logic [31:0] eh, input logic [31:0] el,
                        input string tag);
    int          n_exp, cycles;
    logic        stall_bad;
    logic [31:0] qh, ql;
    n_exp = (o == MD_DIV || o == MD_DIVU) ? N_DIV : N_MULT;
    exp_q.push_back(eh);
    exp_q.push_back(el);
    d_is_md = dmd; bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    @(negedge clk);
    check({tag, " start clr_de"}, 32'(clr_de), 32'(dmd));
    check({tag, " start en_pc"}, 32'(en_pc), 32'(!dmd));
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE;
    cycles = 0;
    stall_bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      cycles++;
      if (clr_de !== dmd || en_fd !== !dmd || en_pc !== !dmd) stall_bad = 1'b1;
    end
    check({tag, " busy cycles"}, 32'(cycles), 32'(n_exp));
    check({tag, " stall during busy"}, 32'(stall_bad), 32'd0);
    check({tag, " stall released"}, 32'(en_fd), 32'd1);
    qh = exp_q.pop_front();
    ql = exp_q.pop_front();
    check({tag, " hi"}, bus.hi, qh);
    check({tag, " lo"}, bus.lo, ql);
    m_hi = eh;
    m_lo = el;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb, eh, el;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'd0,  32'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
    vecs[1] = '{MD_DIVU,  32'd100,       32'd7,        32'd0,  32'd0,  32'd2,         32'd14,        1'b1};
    vecs[2] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd9, 32'd9,  32'd0,         32'h8000_0000, 1'b1};
    vecs[3] = '{MD_DIV,   32'd5,         32'd0,        32'h11, 32'h22, 32'h11,        32'h22,        1'b0};
    vecs[4] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,  32'hFFFF_FFFE, 32'h0000_0001, 1'b1};
    vecs[5] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'd0,  32'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[6] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd0, 32'd0,  32'd1,         32'hFFFF_FFFD, 1'b1};
    vecs[7] = '{MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0,  32'h3FFF_FFFF, 32'h0000_0001, 1'b0};

    reset = 1'b1; d_is_md = 1'b0; hazard_stall = 1'b0;
    bus.start = 1'b0; bus.op = MD_NONE; bus.rs_val = '0; bus.rt_val = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset state", 32'(state_dbg), 32'(IDLE));
    check("reset en_pc", 32'(en_pc), 32'd1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      mt(MD_MTHI, vecs[i].pre_hi);
      mt(MD_MTLO, vecs[i].pre_lo);
      run_md(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dmd, vecs[i].exp_hi, vecs[i].exp_lo,
             $sformatf("vec%0d", i));
    end

    // mthi then mtlo back to back, with an md instruction sitting in D.
    d_is_md = 1'b1;
    bus.start = 1'b1; bus.op = MD_MTHI; bus.rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi no stall", 32'(en_pc), 32'd1);
    @(posedge clk); #1;
    bus.op = MD_MTLO; bus.rs_val = 32'h0000_1234;
    @(negedge clk);
    check("mthi hi", bus.hi, 32'hDEAD_BEEF);
    check("mtlo busy", 32'(bus.busy), 32'd0);
    check("mtlo no stall", 32'(clr_de), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE;
    @(negedge clk);
    check("mtlo lo", bus.lo, 32'h0000_1234);
    check("mtlo hi kept", bus.hi, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    d_is_md = 1'b0;

    // Hazard stall alone, unit idle.
    hazard_stall = 1'b1;
    @(negedge clk);
    check("hazard en_pc", 32'(en_pc), 32'd0);
    check("hazard en_fd", 32'(en_fd), 32'd0);
    check("hazard clr_de", 32'(clr_de), 32'd1);
    @(posedge clk); #1;
    hazard_stall = 1'b0;

    // Reset on busy cycle 3 of a mult; no late write-back afterwards.
    mt(MD_MTHI, 32'h55);
    bus.start = 1'b1; bus.op = MD_MULT; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE;
    repeat (2) begin @(posedge clk); #1; end
    check("pre-reset busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midop reset busy", 32'(bus.busy), 32'd0);
    check("midop reset hi", bus.hi, 32'd0);
    check("midop reset lo", bus.lo, 32'd0);
    repeat (12) @(negedge clk);
    check("no late wb hi", bus.hi, 32'd0);
    check("no late wb lo", bus.lo, 32'd0);
    check("no late busy", 32'(bus.busy), 32'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       rop = MD_MULT;
        1:       rop = MD_MULTU;
        2:       rop = MD_DIV;
        default: rop = MD_DIVU;
      endcase
      ra = $urandom();
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 20);
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      ref_model(rop, ra, rb, eh, el);
      run_md(rop, ra, rb, 1'($urandom_range(0, 1)), eh, el, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
